// File: rtl/b2g_fifo_pkg.sv
// rtl/b2g_fifo_pkg.sv - shared constants and types for the B2G FIFO register slave
package b2g_fifo_pkg;

  // Register map
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // STATUS register bit positions
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_UDF   = 3;

  // CTRL register flush bit
  localparam int CTRL_FLUSH = 0;

  // Response codes
  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  // Decoded bus cycle kind
  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_READ    = 2'd2,
    OP_ILLEGAL = 2'd3
  } bus_op_e;

  // Classify one bus cycle from its qualifier and strobes
  function automatic bus_op_e decode_op(input logic enable, input logic write, input logic read);
    bus_op_e op;
    op = OP_NONE;
    if (enable) begin
      case ({write, read})
        2'b10:   op = OP_WRITE;
        2'b01:   op = OP_READ;
        2'b11:   op = OP_ILLEGAL;
        default: op = OP_NONE;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/b2g_fifo_regif_if.sv
// rtl/b2g_fifo_regif_if.sv - register bus bundle between a host and the B2G FIFO slave
interface b2g_fifo_regif_if #(
  parameter int DATA_W = 8
);

  logic              enable;
  logic              write;
  logic              read;
  logic [1:0]        addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              resp;

  // Host side drives the request, samples the registered reply
  modport master (
    output enable, write, read, addr, wdata,
    input  rdata, resp
  );

  // FIFO slave side
  modport slave (
    input  enable, write, read, addr, wdata,
    output rdata, resp
  );

endinterface

// File: rtl/b2g_fifo_mem.sv
// rtl/b2g_fifo_mem.sv - FIFO storage with pointers, occupancy count and full/empty
module b2g_fifo_mem #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Next state: flush wins, otherwise one guarded push or pop; pointers wrap
  // naturally because DEPTH is a power of two
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (push && !full) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      count_d         = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q - CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/b2g_fifo_regif.sv
// rtl/b2g_fifo_regif.sv - register-mapped FIFO slave; B2G_FIFO_IRQ_EN adds threshold irq
module b2g_fifo_regif
  import b2g_fifo_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  b2g_fifo_regif_if.slave    bus
`ifdef B2G_FIFO_IRQ_EN
  ,
  output logic               irq
`endif
);

  bus_op_e           op;
  logic              push, pop, flush;
  logic [DATA_W-1:0] head;
  logic [CNT_W-1:0]  count;
  logic              full, empty;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              resp_q, resp_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
`ifdef B2G_FIFO_IRQ_EN
  logic [CNT_W-1:0]  thresh_q, thresh_d;
  logic              irq_q, irq_d;
`endif

  assign bus.rdata = rdata_q;
  assign bus.resp  = resp_q;
`ifdef B2G_FIFO_IRQ_EN
  assign irq       = irq_q;
`endif

  b2g_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (bus.wdata),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Classify the current bus cycle
  always_comb begin
    op = decode_op(bus.enable, bus.write, bus.read);
  end

  // Register decode: FIFO control, sticky flags, CTRL and reply next state
  always_comb begin
    rdata_d = rdata_q;
    resp_d  = resp_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
`ifdef B2G_FIFO_IRQ_EN
    thresh_d = thresh_q;
`endif
    case (op)
      OP_ILLEGAL: begin
        rdata_d = '0;
        resp_d  = RESP_ERR;
      end
      OP_WRITE: begin
        rdata_d = '0;
        resp_d  = RESP_OK;
        case (bus.addr)
          ADDR_DATA: begin
            if (full) begin
              ovf_d  = 1'b1;
              resp_d = RESP_ERR;
            end else begin
              push = 1'b1;
            end
          end
          ADDR_STATUS: begin
            if (bus.wdata[STAT_UDF]) udf_d = 1'b0;
            if (bus.wdata[STAT_OVF]) ovf_d = 1'b0;
          end
          ADDR_COUNT: begin
            resp_d = RESP_ERR;
          end
          default: begin
            flush = bus.wdata[CTRL_FLUSH];
`ifdef B2G_FIFO_IRQ_EN
            thresh_d = bus.wdata[CNT_W:1];
`endif
          end
        endcase
      end
      OP_READ: begin
        resp_d = RESP_OK;
        case (bus.addr)
          ADDR_DATA: begin
            if (empty) begin
              rdata_d = '0;
              udf_d   = 1'b1;
              resp_d  = RESP_ERR;
            end else begin
              rdata_d = head;
              pop     = 1'b1;
            end
          end
          ADDR_STATUS: begin
            rdata_d             = '0;
            rdata_d[STAT_UDF]   = udf_q;
            rdata_d[STAT_OVF]   = ovf_q;
            rdata_d[STAT_FULL]  = full;
            rdata_d[STAT_EMPTY] = empty;
          end
          ADDR_COUNT: begin
            rdata_d = DATA_W'(count);
          end
          default: begin
            rdata_d = '0;
`ifdef B2G_FIFO_IRQ_EN
            rdata_d[CNT_W:0] = {thresh_q, 1'b0};
`endif
          end
        endcase
      end
      default: ;
    endcase
  end

`ifdef B2G_FIFO_IRQ_EN
  // Interrupt follows the settled state one cycle later
  always_comb begin
    irq_d = ((thresh_q != '0) && (count >= thresh_q)) || ovf_q;
  end
`endif

  // Reply, flag and control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      resp_q   <= RESP_OK;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
`ifdef B2G_FIFO_IRQ_EN
      thresh_q <= CNT_W'(DEPTH);
      irq_q    <= 1'b0;
`endif
    end else begin
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
`ifdef B2G_FIFO_IRQ_EN
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
`endif
    end
  end

endmodule

// File: tb/tb_b2g_fifo_regif.sv
// tb/tb_b2g_fifo_regif.sv - scoreboard bench for b2g_fifo_regif (DATA_W=8, DEPTH=4)
module tb_b2g_fifo_regif;

  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] rdata;
    logic       resp;
    bit         chk_rd;
    int         id;
  } exp_t;

  logic clk;
  logic rst;
`ifdef B2G_FIFO_IRQ_EN
  logic irq;
`endif

  b2g_fifo_regif_if #(.DATA_W(8)) bus ();

  b2g_fifo_regif #(
    .DATA_W (8),
    .DEPTH  (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef B2G_FIFO_IRQ_EN
    ,
    .irq (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int op_id    = 0;

  exp_t       sb[$];
  logic [7:0] mq[$];
  bit         m_ovf, m_udf;
  int         m_thresh;
  bit         model_irq;
  bit         irq_hist;
  bit         irq_exp;
  bit         mon_take;
  exp_t       me;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  function automatic bit irq_rule();
    return ((m_thresh != 0) && (mq.size() >= m_thresh)) || m_ovf;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf     = 0;
    m_udf     = 0;
    m_thresh  = DEPTH;
    model_irq = 0;
  endtask

  // One bus cycle; the model predicts the reply and queues it
  task automatic acc(input bit en, input bit wr, input bit rd, input logic [1:0] a, input logic [7:0] wd);
    exp_t e;
    @(negedge clk);
    bus.enable = en;
    bus.write  = wr;
    bus.read   = rd;
    bus.addr   = a;
    bus.wdata  = wd;
    if (en && (wr || rd)) begin
      e.id     = op_id++;
      e.rdata  = 8'h00;
      e.resp   = 1'b0;
      e.chk_rd = 0;
      if (wr && rd) begin
        e.resp   = 1'b1;
        e.chk_rd = 1;
      end else if (wr) begin
        case (a)
          2'd0: if (mq.size() < DEPTH) mq.push_back(wd); else begin m_ovf = 1; e.resp = 1'b1; end
          2'd1: begin if (wd[3]) m_udf = 0; if (wd[2]) m_ovf = 0; end
          2'd2: e.resp = 1'b1;
          default: begin
            if (wd[0]) mq.delete();
`ifdef B2G_FIFO_IRQ_EN
            m_thresh = (wd >> 1) & 7;
`endif
          end
        endcase
      end else begin
        e.chk_rd = 1;
        case (a)
          2'd0: if (mq.size() > 0) e.rdata = mq.pop_front(); else begin m_udf = 1; e.resp = 1'b1; end
          2'd1: e.rdata = {4'd0, m_udf, m_ovf, mq.size() == DEPTH, mq.size() == 0};
          2'd2: e.rdata = 8'(mq.size());
          default: begin
`ifdef B2G_FIFO_IRQ_EN
            e.rdata = 8'(m_thresh * 2);
`else
            e.rdata = 8'h00;
`endif
          end
        endcase
      end
      sb.push_back(e);
    end
    model_irq = irq_rule();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.enable = 0;
      bus.write  = 0;
      bus.read   = 0;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    acc(1, 1, 0, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    acc(1, 0, 1, a, 8'h00);
  endtask

  // Monitor: every accepted access yields one reply one edge later
  always @(posedge clk) begin
    mon_take = !rst && bus.enable && (bus.write || bus.read);
    irq_exp  = irq_hist;
    irq_hist = rst ? 1'b0 : model_irq;
    #1;
    if (mon_take) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        me = sb.pop_front();
        chk($sformatf("acc%0d.resp", me.id), int'(bus.resp), int'(me.resp));
        if (me.chk_rd) chk($sformatf("acc%0d.rdata", me.id), int'(bus.rdata), int'(me.rdata));
      end
    end
`ifdef B2G_FIFO_IRQ_EN
    if (!rst) chk("irq", int'(irq), int'(irq_exp));
`endif
  end

  initial begin
    #300000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] wd;
    bit         en, w, r;
    int         k;
    rst        = 1;
    bus.enable = 0;
    bus.write  = 0;
    bus.read   = 0;
    bus.addr   = 2'd0;
    bus.wdata  = 8'h00;
    model_reset();
    irq_hist   = 0;
    repeat (3) @(negedge clk);
    chk("reset.rdata", int'(bus.rdata), 0);
    chk("reset.resp", int'(bus.resp), 0);
`ifdef B2G_FIFO_IRQ_EN
    chk("reset.irq", int'(irq), 0);
`endif
    rst = 0;
    idle(2);
    rd(2'd1); rd(2'd2); rd(2'd3);

    // FIFO order and occupancy
    wr(0, 8'h11); wr(0, 8'h22); wr(0, 8'h33); wr(0, 8'h44);
    rd(2); rd(0); rd(0); rd(0); rd(0); rd(2);

    // Overflow, W1C clear
    wr(0, 8'h01); wr(0, 8'h02); wr(0, 8'h03); wr(0, 8'h04); wr(0, 8'h55);
    rd(1); wr(1, 8'h04); rd(1);
    rd(0); rd(0); rd(0); rd(0);

    // Underflow
    rd(0); rd(1); wr(1, 8'h08); rd(1);

    // Illegal access and COUNT write
    wr(0, 8'h66);
    acc(1, 1, 1, 2'd0, 8'h77);
    rd(2); wr(2, 8'h03); rd(2);
    acc(1, 0, 0, 2'd0, 8'h88); acc(0, 1, 0, 2'd0, 8'h99);
    rd(2);

    // Flush and wrap
    wr(0, 8'hA0); wr(0, 8'hA1);
    wr(3, 8'h01); rd(2); rd(1);
    for (int i = 0; i < 6; i++) begin
      wr(0, 8'(8'hC0 + i));
      rd(0);
    end
    idle(2);

    // Threshold interrupt, then reset in the middle of a burst
    wr(3, 8'h04); rd(3);
    wr(0, 8'h5A); wr(0, 8'h5B);
    idle(2);
    rd(0);
    idle(2);
    wr(0, 8'hA1); wr(0, 8'hA2);
    @(negedge clk);
    bus.enable = 1; bus.write = 1; bus.read = 0; bus.addr = 2'd0; bus.wdata = 8'hA3;
    #2;
    rst = 1;
    model_reset();
    #1;
    chk("midrst.rdata", int'(bus.rdata), 0);
    chk("midrst.resp", int'(bus.resp), 0);
`ifdef B2G_FIFO_IRQ_EN
    chk("midrst.irq", int'(irq), 0);
`endif
    @(negedge clk);
    bus.enable = 0; bus.write = 0;
    @(negedge clk);
    rst = 0;
    idle(1);
    rd(1); rd(2); rd(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(7) != 0);
      k  = $urandom_range(9);
      w  = (k == 0) || (k >= 2 && k <= 5);
      r  = (k == 0) || (k >= 6);
      wd = 8'($urandom);
      k  = $urandom_range(7);
      if (k <= 3) begin
        acc(en, w, r, 2'd0, wd);
      end else if (k == 4) begin
        acc(en, w, r, 2'd1, wd);
      end else if (k == 5) begin
        acc(en, w, r, 2'd2, wd);
      end else begin
        if ($urandom_range(3) != 0) wd[0] = 1'b0;
        acc(en, w, r, 2'd3, wd);
      end
    end
    idle(4);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
